ifft_butterfly_pipe: RTL

//  Pipelined radix-2 decimation-in-frequency butterfly for the inverse FFT path; inverse counterpart of

---
 rtl/butterfly_pkg.sv | 21 ++
 rtl/round_sat.sv | 35 +++
 rtl/ifft_butterfly_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/butterfly_pkg.sv
// rtl/butterfly_pkg.sv - shared fixed-point complex word format and pack/unpack helpers
package butterfly_pkg;

  localparam int WORD_MID  = 16;
  localparam int WORD_SZ   = 32;
  localparam int FRAC_BITS = 6;

  function automatic logic signed [WORD_MID-1:0] cplx_re(input logic [WORD_SZ-1:0] x);
    return x[WORD_SZ-1:WORD_MID];
  endfunction

  function automatic logic signed [WORD_MID-1:0] cplx_im(input logic [WORD_SZ-1:0] x);
    return x[WORD_MID-1:0];
  endfunction

  function automatic logic [WORD_SZ-1:0] cplx_pack(input logic [WORD_MID-1:0] re,
                                                  input logic [WORD_MID-1:0] im);
    return {re, im};
  endfunction

endpackage

// File: rtl/round_sat.sv
// rtl/round_sat.sv - combinational round-half-up, arithmetic shift and clamp to OUT_W signed
module round_sat #(
  parameter int IN_W  = 17,
  parameter int SHIFT = 1,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic        [OUT_W-1:0] dout,
  output logic                    sat
);

  // One guard bit so the rounding constant can never wrap the input.
  localparam int EW = IN_W + 1;
  localparam logic signed [EW-1:0] HALF = {{(EW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EW-1:0] biased;
  logic signed [EW-1:0] shifted;

  always_comb begin
    biased  = {din[IN_W-1], din} + HALF;
    shifted = biased >>> SHIFT;
    dout    = shifted[OUT_W-1:0];
    sat     = 1'b0;
    if (shifted > MAXV) begin
      dout = MAXV[OUT_W-1:0];
      sat  = 1'b1;
    end else if (shifted < MINV) begin
      dout = MINV[OUT_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/ifft_butterfly_pipe.sv
// rtl/ifft_butterfly_pipe.sv - 3-stage inverse radix-2 DIF butterfly with elastic valid/ready
module ifft_butterfly_pipe
  import butterfly_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WORD_SZ-1:0] i_A,
  input  logic [WORD_SZ-1:0] i_B,
  input  logic [WORD_SZ-1:0] i_twiddle,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WORD_SZ-1:0] o_A,
  output logic [WORD_SZ-1:0] o_B,
  output logic               o_sat
);

  localparam int SW = WORD_MID + 1;
  localparam int PW = 2 * WORD_MID + 1;
  localparam int AW = PW + 1;

  logic en1, en2, en3;
  logic v1, v2;

  logic signed [WORD_MID-1:0] a_re, a_im, b_re, b_im;
  logic signed [SW-1:0]       s1_re, s1_im, d1_re, d1_im;
  logic        [WORD_SZ-1:0]  w1;
  logic signed [WORD_MID-1:0] w_re, w_im;

  logic signed [SW-1:0] s2_re, s2_im;
  logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;

  logic signed [AW-1:0]       acc_re, acc_im;
  logic        [WORD_MID-1:0] ra_re, ra_im, rb_re, rb_im;
  logic        [3:0]          sat_v;

  // Ready ripples back combinationally so a full pipe still streams at one beat per cycle.
  assign en3     = !o_valid || i_ready;
  assign en2     = !v2 || en3;
  assign en1     = !v1 || en2;
  assign o_ready = en1;

  assign a_re = cplx_re(i_A);
  assign a_im = cplx_im(i_A);
  assign b_re = cplx_re(i_B);
  assign b_im = cplx_im(i_B);
  assign w_re = cplx_re(w1);
  assign w_im = cplx_im(w1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1    <= 1'b0;
      s1_re <= '0;
      s1_im <= '0;
      d1_re <= '0;
      d1_im <= '0;
      w1    <= '0;
    end else if (en1) begin
      v1 <= i_valid;
      if (i_valid) begin
        s1_re <= {a_re[WORD_MID-1], a_re} + {b_re[WORD_MID-1], b_re};
        s1_im <= {a_im[WORD_MID-1], a_im} + {b_im[WORD_MID-1], b_im};
        d1_re <= {a_re[WORD_MID-1], a_re} - {b_re[WORD_MID-1], b_re};
        d1_im <= {a_im[WORD_MID-1], a_im} - {b_im[WORD_MID-1], b_im};
        w1    <= i_twiddle;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v2    <= 1'b0;
      s2_re <= '0;
      s2_im <= '0;
      p_rr  <= '0;
      p_ii  <= '0;
      p_ir  <= '0;
      p_ri  <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        s2_re <= s1_re;
        s2_im <= s1_im;
        p_rr  <= PW'(d1_re) * PW'(w_re);
        p_ii  <= PW'(d1_im) * PW'(w_im);
        p_ir  <= PW'(d1_im) * PW'(w_re);
        p_ri  <= PW'(d1_re) * PW'(w_im);
      end
    end
  end

  // Multiplying by conj(W) flips the sign of every wi term.
  assign acc_re = AW'(p_rr) + AW'(p_ii);
  assign acc_im = AW'(p_ir) - AW'(p_ri);

  round_sat #(.IN_W(SW), .SHIFT(1), .OUT_W(WORD_MID)) u_rs_sre (.din(s2_re),  .dout(ra_re), .sat(sat_v[0]));
  round_sat #(.IN_W(SW), .SHIFT(1), .OUT_W(WORD_MID)) u_rs_sim (.din(s2_im),  .dout(ra_im), .sat(sat_v[1]));
  round_sat #(.IN_W(AW), .SHIFT(FRAC_BITS + 1), .OUT_W(WORD_MID)) u_rs_pre (.din(acc_re), .dout(rb_re), .sat(sat_v[2]));
  round_sat #(.IN_W(AW), .SHIFT(FRAC_BITS + 1), .OUT_W(WORD_MID)) u_rs_pim (.din(acc_im), .dout(rb_im), .sat(sat_v[3]));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_A     <= '0;
      o_B     <= '0;
      o_sat   <= 1'b0;
    end else if (en3) begin
      o_valid <= v2;
      if (v2) begin
        o_A   <= cplx_pack(ra_re, ra_im);
        o_B   <= cplx_pack(rb_re, rb_im);
        o_sat <= |sat_v;
      end
    end
  end

endmodule
